led_driver: RTL

// - Output stage between the SoC's 8-bit LED register and the four board LEDs.
// - soc_led[3:0] carries LED state and soc_led[7:4] carries per-channel blink enables.
// - Adds three things before the pins:
//   - pulse stretching, so single-cycle SoC writes stay visible;
//   - optional per-channel blinking;
//   - global PWM dimming.
// - Sits directly downstream of attosoc, on the BUFG-driven system clock.

---
 rtl/led_pkg.sv | 28 ++
 rtl/led_channel.sv | 61 ++++++
 rtl/led_driver.sv | 81 ++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared constants and width helpers for the LED output stage.
// Latency: n/a (package only).
// Backpressure: n/a.
package led_pkg;

    localparam int N_LED = 4;

    // Ceiling log2. Used at elaboration time to size counters.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Counter width for a counter that must hold values 0..n-1.
    // Never returns zero, so a degenerate range still gets a legal vector.
    function automatic int cnt_width(input int n);
        int w;
        w = clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED lane: rising-edge pulse stretcher, blink gate, PWM gate and output flop.
// Latency: 1 clk edge from state/blink_en/blink_phase/pwm_on to led.
// Backpressure: none; the lane accepts a new state every cycle.
module led_channel #(
    parameter int STRETCH_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic state,
    input  logic blink_en,
    input  logic blink_phase,
    input  logic pwm_on,
    output logic led
);
    import led_pkg::*;

    localparam int            SW     = cnt_width(STRETCH_CYCLES + 1);
    localparam logic [SW-1:0] S_LOAD = SW'(STRETCH_CYCLES);
    localparam logic [SW-1:0] S_ONE  = SW'(1);

    logic          state_d;
    logic [SW-1:0] stretch_cnt;
    logic          rise;
    logic          eff;

    assign rise = state & ~state_d;

    // The lane is lit while the state bit is high or a stretch is still running.
    assign eff  = state | (stretch_cnt != '0);

    // Delayed copy of the state bit for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_d <= 1'b0;
        end else begin
            state_d <= state;
        end
    end

    // A rise (re)loads the full stretch time; otherwise count down to zero.
    // Reloading rather than adding keeps the worst-case on-time bounded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stretch_cnt <= '0;
        end else if (rise) begin
            stretch_cnt <= S_LOAD;
        end else if (stretch_cnt != '0) begin
            stretch_cnt <= stretch_cnt - S_ONE;
        end
    end

    // Output flop: stretching only extends eff, so blink and PWM still gate it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led <= 1'b0;
        end else begin
            led <= eff & (blink_en ? blink_phase : 1'b1) & pwm_on;
        end
    end

endmodule

// File: rtl/led_driver.sv
// SoC LED register to board pins: input register, shared blink/PWM timebase, per-lane stretch.
// Latency: 2 clk edges from soc_led to led (input register + lane output flop).
// Backpressure: none; soc_led is sampled every cycle.
module led_driver #(
    parameter int PWM_BITS       = 4,
    parameter int DUTY           = 16,
    parameter int BLINK_DIV      = 6000000,
    parameter int STRETCH_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] soc_led,
    output logic [3:0] led
);
    import led_pkg::*;

    localparam int                  BW         = cnt_width(BLINK_DIV);
    localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [BW-1:0]       BLINK_ONE  = BW'(1);
    localparam int                  PW1        = PWM_BITS + 1;
    // One extra bit so DUTY == 2**PWM_BITS compares as always-on.
    localparam logic [PWM_BITS:0]   DUTY_W     = PW1'(DUTY);
    localparam logic [PWM_BITS-1:0] PWM_ONE    = PWM_BITS'(1);

    logic [7:0]          in_q;
    logic [PWM_BITS-1:0] pwm_ctr;
    logic [BW-1:0]       blink_ctr;
    logic                blink_phase;
    logic                blink_wrap;
    logic                pwm_on;

    assign blink_wrap = (blink_ctr == BLINK_LAST);
    assign pwm_on     = ({1'b0, pwm_ctr} < DUTY_W);

    // Register the SoC LED word; nothing downstream sees soc_led combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q <= '0;
        end else begin
            in_q <= soc_led;
        end
    end

    // Free-running PWM counter, wraps naturally at 2**PWM_BITS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_ctr <= '0;
        end else begin
            pwm_ctr <= pwm_ctr + PWM_ONE;
        end
    end

    // Blink timebase: BLINK_DIV cycles per half-period, phase starts in the on state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_ctr   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_wrap) begin
            blink_ctr   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_ctr   <= blink_ctr + BLINK_ONE;
        end
    end

    // One lane per LED: low nibble is state, high nibble is that lane's blink enable.
    for (genvar i = 0; i < N_LED; i++) begin : g_ch
        led_channel #(
            .STRETCH_CYCLES (STRETCH_CYCLES)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .state       (in_q[i]),
            .blink_en    (in_q[i + N_LED]),
            .blink_phase (blink_phase),
            .pwm_on      (pwm_on),
            .led         (led[i])
        );
    end

endmodule
